// File: rtl/uart_bcd_tx.sv
// rtl/uart_bcd_tx.sv - parametrised UART transmitter sending packed BCD digits as ASCII
// Digits go out most-significant first, optionally followed by a terminator byte.
module uart_bcd_tx #(
  parameter int          CLK_DIV   = 434,
  parameter int          DIGITS    = 2,
  parameter int          PARITY    = 0,
  parameter int          STOP_BITS = 1,
  parameter int          TERM_EN   = 1,
  parameter logic [7:0]  TERM_CHAR = 8'h0D
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic                  tx_out
);

  localparam int BAUD_W    = $clog2(CLK_DIV);
  localparam int CHAR_W    = $clog2(DIGITS + 1);
  localparam int NUM_CHARS = DIGITS + TERM_EN;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [CHAR_W-1:0] CHAR_LAST = CHAR_W'(NUM_CHARS - 1);
  localparam logic [CHAR_W-1:0] TERM_IDX  = CHAR_W'(DIGITS);
  localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [BAUD_W-1:0]     baud_cnt_q, baud_cnt_d;
  logic [3:0]            bit_idx_q, bit_idx_d;
  logic [CHAR_W-1:0]     char_idx_q, char_idx_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [4*DIGITS-1:0]   bcd_shift;
  logic [3:0]            digit;
  logic                  is_term;
  logic [7:0]            cur_char;
  logic                  parity_bit;
  logic                  baud_tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      char_idx_q <= '0;
      bcd_q      <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      char_idx_q <= char_idx_d;
      bcd_q      <= bcd_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Current character is derived from the latched digits, stable for a whole frame.
  always_comb begin
    bcd_shift  = bcd_q >> (4 * (DIGITS - 1 - int'(char_idx_q)));
    digit      = bcd_shift[3:0];
    is_term    = (TERM_EN != 0) && (char_idx_q == TERM_IDX);
    if (is_term) begin
      cur_char = TERM_CHAR;
    end else if (digit > 4'd9) begin
      cur_char = 8'h3F;
    end else begin
      cur_char = {4'h3, digit};
    end
    parity_bit = (^cur_char) ^ (PARITY == 2);
  end

  assign baud_tick = (baud_cnt_q == BAUD_LAST);

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    char_idx_d = char_idx_q;
    bcd_d      = bcd_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          bcd_d      = bcd;
          char_idx_d = '0;
          bit_idx_d  = '0;
          baud_cnt_d = '0;
          state_d    = S_START;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end
      end
      S_START, S_DATA, S_PARITY, S_STOP: begin
        if (!baud_tick) begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end else begin
          baud_cnt_d = '0;
          case (state_q)
            S_START: begin
              state_d   = S_DATA;
              bit_idx_d = '0;
              tx_d      = cur_char[0];
            end
            S_DATA: begin
              if (bit_idx_q == 4'd7) begin
                bit_idx_d = '0;
                if (PARITY != 0) begin
                  state_d = S_PARITY;
                  tx_d    = parity_bit;
                end else begin
                  state_d = S_STOP;
                  tx_d    = 1'b1;
                end
              end else begin
                bit_idx_d = bit_idx_q + 4'd1;
                tx_d      = cur_char[bit_idx_q[2:0] + 3'd1];
              end
            end
            S_PARITY: begin
              state_d   = S_STOP;
              bit_idx_d = '0;
              tx_d      = 1'b1;
            end
            default: begin
              if (bit_idx_q != STOP_LAST) begin
                bit_idx_d = bit_idx_q + 4'd1;
                tx_d      = 1'b1;
              end else if (char_idx_q == CHAR_LAST) begin
                state_d    = S_IDLE;
                bit_idx_d  = '0;
                char_idx_d = '0;
                tx_d       = 1'b1;
                busy_d     = 1'b0;
                done_d     = 1'b1;
              end else begin
                // Next start bit follows the last stop bit with no idle gap.
                state_d    = S_START;
                bit_idx_d  = '0;
                char_idx_d = char_idx_q + 1'b1;
                tx_d       = 1'b0;
              end
            end
          endcase
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign tx_out = tx_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_uart_bcd_tx.sv
// tb/tb_uart_bcd_tx.sv - self-checking bench for uart_bcd_tx over several parameter sets
module tb_uart_bcd_tx;

  localparam int N = 5;
  localparam int         CDIV [N] = '{4, 4, 4, 4, 3};
  localparam int         CDIG [N] = '{2, 1, 1, 4, 3};
  localparam int         CPAR [N] = '{0, 1, 2, 0, 2};
  localparam int         CSTP [N] = '{1, 1, 1, 2, 2};
  localparam int         CTEN [N] = '{1, 0, 0, 0, 1};
  localparam logic [7:0] CTRM [N] = '{8'h0D, 8'h0D, 8'h0D, 8'h0D, 8'h0A};

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   start_v = '0;
  logic [31:0]    bcd_v [N];
  logic [N-1:0]   busy_v, done_v, tx_v;

  int vectors = 0;
  int miscompares = 0;

  logic cap_tx[$], cap_busy[$], cap_done[$];
  logic exp_tx[$], exp_busy[$], exp_done[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    uart_bcd_tx #(
      .CLK_DIV(CDIV[g]), .DIGITS(CDIG[g]), .PARITY(CPAR[g]),
      .STOP_BITS(CSTP[g]), .TERM_EN(CTEN[g]), .TERM_CHAR(CTRM[g])
    ) u_dut (
      .clk(clk), .rst(rst), .start(start_v[g]),
      .bcd(bcd_v[g][4*CDIG[g]-1:0]),
      .busy(busy_v[g]), .done(done_v[g]), .tx_out(tx_v[g])
    );
  end

  // Reference model: characters and frames computed from arithmetic on the digit value.
  function automatic logic [7:0] char_at(int w, logic [31:0] val, int c);
    int d;
    if (c >= CDIG[w]) return CTRM[w];
    d = int'((val / (32'd1 << (4 * (CDIG[w] - 1 - c)))) % 16);
    return (d < 10) ? 8'(48 + d) : 8'h3F;
  endfunction

  function automatic int msg_cycles(int w);
    return (CDIG[w] + CTEN[w]) * (9 + (CPAR[w] != 0 ? 1 : 0) + CSTP[w]) * CDIV[w];
  endfunction

  task automatic clear_all();
    cap_tx.delete(); cap_busy.delete(); cap_done.delete();
    exp_tx.delete(); exp_busy.delete(); exp_done.delete();
  endtask

  task automatic append_message(int w, logic [31:0] val);
    logic bits[$];
    logic [7:0] ch;
    int ones;
    for (int c = 0; c < CDIG[w] + CTEN[w]; c++) begin
      ch = char_at(w, val, c);
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(ch[i]);
      ones = $countones(ch);
      if (CPAR[w] == 1) bits.push_back(ones % 2 == 1);
      if (CPAR[w] == 2) bits.push_back(ones % 2 == 0);
      for (int s = 0; s < CSTP[w]; s++) bits.push_back(1'b1);
    end
    foreach (bits[b]) begin
      for (int r = 0; r < CDIV[w]; r++) begin
        exp_tx.push_back(bits[b]); exp_busy.push_back(1'b1); exp_done.push_back(1'b0);
      end
    end
    exp_tx.push_back(1'b1); exp_busy.push_back(1'b0); exp_done.push_back(1'b1);
  endtask

  task automatic append_idle();
    exp_tx.push_back(1'b1); exp_busy.push_back(1'b0); exp_done.push_back(1'b0);
  endtask

  task automatic send(int w, logic [31:0] val);
    @(negedge clk);
    bcd_v[w]   = val;
    start_v[w] = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Samples n negedges starting now; optionally pulses start over [chg_at, chg_at+chg_len).
  task automatic capture(int w, int n, int chg_at, int chg_len, logic [31:0] chg_bcd);
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      if (k == chg_at) begin
        start_v[w] = 1'b1;
        bcd_v[w]   = chg_bcd;
      end
      if (k == chg_at + chg_len) start_v[w] = 1'b0;
      cap_tx.push_back(tx_v[w]);
      cap_busy.push_back(busy_v[w]);
      cap_done.push_back(done_v[w]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int w = 0; w < N; w++) begin
      vectors++;
      if ({tx_v[w], busy_v[w], done_v[w]} !== 3'b100) begin
        miscompares++;
        $display("FAIL reset dut%0d: tx/busy/done=%b%b%b expected 100", w, tx_v[w], busy_v[w], done_v[w]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_default_frames();
    int busy_cnt, done_cnt;
    clear_all();
    append_message(0, 32'h12);
    append_idle();
    send(0, 32'h12);
    start_v[0] = 1'b0;
    capture(0, exp_tx.size(), -1, 0, 0);
    busy_cnt = 0; done_cnt = 0;
    for (int k = 0; k < exp_tx.size(); k++) begin
      vectors++;
      if ({cap_tx[k], cap_busy[k], cap_done[k]} !== {exp_tx[k], exp_busy[k], exp_done[k]}) begin
        miscompares++;
        $display("FAIL default_frames cycle %0d: tx/busy/done=%b%b%b expected %b%b%b", k,
                 cap_tx[k], cap_busy[k], cap_done[k], exp_tx[k], exp_busy[k], exp_done[k]);
      end
      busy_cnt += (cap_busy[k] === 1'b1) ? 1 : 0;
      done_cnt += (cap_done[k] === 1'b1) ? 1 : 0;
    end
    vectors++;
    if (busy_cnt != 120) begin
      miscompares++;
      $display("FAIL default_busy_len: got %0d expected 120", busy_cnt);
    end
    vectors++;
    if (done_cnt != 1 || cap_done[120] !== 1'b1) begin
      miscompares++;
      $display("FAIL default_done: count %0d done@120=%b expected 1 and 1", done_cnt, cap_done[120]);
    end
  endtask

  task automatic test_parity();
    int busy_cnt;
    for (int w = 1; w <= 2; w++) begin
      clear_all();
      append_message(w, 32'h1);
      append_idle();
      send(w, 32'h1);
      start_v[w] = 1'b0;
      capture(w, exp_tx.size(), -1, 0, 0);
      busy_cnt = 0;
      for (int k = 0; k < exp_tx.size(); k++) begin
        vectors++;
        if ({cap_tx[k], cap_busy[k], cap_done[k]} !== {exp_tx[k], exp_busy[k], exp_done[k]}) begin
          miscompares++;
          $display("FAIL parity dut%0d cycle %0d: tx/busy/done=%b%b%b expected %b%b%b", w, k,
                   cap_tx[k], cap_busy[k], cap_done[k], exp_tx[k], exp_busy[k], exp_done[k]);
        end
        busy_cnt += (cap_busy[k] === 1'b1) ? 1 : 0;
      end
      vectors++;
      if (busy_cnt != 44) begin
        miscompares++;
        $display("FAIL parity_busy_len dut%0d: got %0d expected 44", w, busy_cnt);
      end
      vectors++;
      if (cap_tx[9*4+2] !== (w == 1 ? 1'b1 : 1'b0)) begin
        miscompares++;
        $display("FAIL parity_bit dut%0d: got %b expected %b", w, cap_tx[9*4+2], (w == 1));
      end
    end
  endtask

  task automatic test_invalid_digits();
    logic [7:0] first;
    clear_all();
    append_message(0, 32'hA7);
    append_idle();
    send(0, 32'hA7);
    start_v[0] = 1'b0;
    capture(0, exp_tx.size(), -1, 0, 0);
    for (int k = 0; k < exp_tx.size(); k++) begin
      vectors++;
      if ({cap_tx[k], cap_busy[k], cap_done[k]} !== {exp_tx[k], exp_busy[k], exp_done[k]}) begin
        miscompares++;
        $display("FAIL invalid_digits cycle %0d: tx/busy/done=%b%b%b expected %b%b%b", k,
                 cap_tx[k], cap_busy[k], cap_done[k], exp_tx[k], exp_busy[k], exp_done[k]);
      end
    end
    for (int i = 0; i < 8; i++) first[i] = cap_tx[(1 + i) * 4 + 2];
    vectors++;
    if (first !== 8'h3F) begin
      miscompares++;
      $display("FAIL invalid_first_char: got %h expected 3f", first);
    end
  endtask

  task automatic test_two_stop();
    int busy_cnt;
    clear_all();
    append_message(3, 32'h9021);
    append_idle();
    send(3, 32'h9021);
    start_v[3] = 1'b0;
    capture(3, exp_tx.size(), -1, 0, 0);
    busy_cnt = 0;
    for (int k = 0; k < exp_tx.size(); k++) begin
      vectors++;
      if ({cap_tx[k], cap_busy[k], cap_done[k]} !== {exp_tx[k], exp_busy[k], exp_done[k]}) begin
        miscompares++;
        $display("FAIL two_stop cycle %0d: tx/busy/done=%b%b%b expected %b%b%b", k,
                 cap_tx[k], cap_busy[k], cap_done[k], exp_tx[k], exp_busy[k], exp_done[k]);
      end
      busy_cnt += (cap_busy[k] === 1'b1) ? 1 : 0;
    end
    vectors++;
    if (busy_cnt != 176) begin
      miscompares++;
      $display("FAIL two_stop_busy_len: got %0d expected 176", busy_cnt);
    end
  endtask

  task automatic test_random();
    logic [31:0] val;
    for (int w = 0; w < N; w++) begin
      for (int r = 0; r < 3; r++) begin
        val = $urandom;
        clear_all();
        append_message(w, val);
        append_idle();
        send(w, val);
        start_v[w] = 1'b0;
        capture(w, exp_tx.size(), -1, 0, 0);
        for (int k = 0; k < exp_tx.size(); k++) begin
          vectors++;
          if ({cap_tx[k], cap_busy[k], cap_done[k]} !== {exp_tx[k], exp_busy[k], exp_done[k]}) begin
            miscompares++;
            $display("FAIL random dut%0d bcd %h cycle %0d: tx/busy/done=%b%b%b expected %b%b%b", w, val, k,
                     cap_tx[k], cap_busy[k], cap_done[k], exp_tx[k], exp_busy[k], exp_done[k]);
          end
        end
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [31:0] val, other;
    int t;
    t = msg_cycles(0);
    for (int pass = 0; pass < 2; pass++) begin
      val   = $urandom;
      other = ~val;
      clear_all();
      append_message(0, val);
      append_idle();
      send(0, val);
      start_v[0] = 1'b0;
      if (pass == 0) capture(0, exp_tx.size(), 30 + $urandom_range(0, 40), 2, other);
      else           capture(0, exp_tx.size(), t - 1, 1, other);
      for (int k = 0; k < exp_tx.size(); k++) begin
        vectors++;
        if ({cap_tx[k], cap_busy[k], cap_done[k]} !== {exp_tx[k], exp_busy[k], exp_done[k]}) begin
          miscompares++;
          $display("FAIL ignore_start pass %0d cycle %0d: tx/busy/done=%b%b%b expected %b%b%b", pass, k,
                   cap_tx[k], cap_busy[k], cap_done[k], exp_tx[k], exp_busy[k], exp_done[k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] val;
    int t;
    t   = msg_cycles(0);
    val = $urandom;
    clear_all();
    append_message(0, val);
    append_message(0, val);
    append_idle();
    send(0, val);
    capture(0, exp_tx.size(), 0, t + 2, val);
    for (int k = 0; k < exp_tx.size(); k++) begin
      vectors++;
      if ({cap_tx[k], cap_busy[k], cap_done[k]} !== {exp_tx[k], exp_busy[k], exp_done[k]}) begin
        miscompares++;
        $display("FAIL back_to_back cycle %0d: tx/busy/done=%b%b%b expected %b%b%b", k,
                 cap_tx[k], cap_busy[k], cap_done[k], exp_tx[k], exp_busy[k], exp_done[k]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] val;
    int k_rst;
    val   = $urandom;
    k_rst = 44 + $urandom_range(0, 31);
    clear_all();
    append_message(0, val);
    send(0, val);
    start_v[0] = 1'b0;
    capture(0, k_rst + 1, -1, 0, 0);
    for (int k = 0; k <= k_rst; k++) begin
      vectors++;
      if ({cap_tx[k], cap_busy[k], cap_done[k]} !== {exp_tx[k], exp_busy[k], exp_done[k]}) begin
        miscompares++;
        $display("FAIL reset_mid_prefix cycle %0d: tx/busy/done=%b%b%b expected %b%b%b", k,
                 cap_tx[k], cap_busy[k], cap_done[k], exp_tx[k], exp_busy[k], exp_done[k]);
      end
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({tx_v[0], busy_v[0], done_v[0]} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_mid_frame: tx/busy/done=%b%b%b expected 100", tx_v[0], busy_v[0], done_v[0]);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({tx_v[0], busy_v[0], done_v[0]} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_mid_stays_idle: tx/busy/done=%b%b%b expected 100", tx_v[0], busy_v[0], done_v[0]);
    end
    val = $urandom;
    clear_all();
    append_message(0, val);
    append_idle();
    send(0, val);
    start_v[0] = 1'b0;
    capture(0, exp_tx.size(), -1, 0, 0);
    for (int k = 0; k < exp_tx.size(); k++) begin
      vectors++;
      if ({cap_tx[k], cap_busy[k], cap_done[k]} !== {exp_tx[k], exp_busy[k], exp_done[k]}) begin
        miscompares++;
        $display("FAIL reset_mid_resend cycle %0d: tx/busy/done=%b%b%b expected %b%b%b", k,
                 cap_tx[k], cap_busy[k], cap_done[k], exp_tx[k], exp_busy[k], exp_done[k]);
      end
    end
  endtask

  initial begin
    for (int w = 0; w < N; w++) bcd_v[w] = '0;
    test_reset();
    test_default_frames();
    test_parity();
    test_invalid_digits();
    test_two_stop();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_bcd_tx.md
Name: uart_bcd_tx

Overview:
- Parametrised UART transmitter. Converts a packed vector of BCD digits to ASCII and sends one serial frame per character, most-significant digit first.
- After the digits it optionally sends a terminator character.
- Successor of the fixed two-digit BCD UART: digit count, baud divider, parity mode, stop-bit count and terminator are all parameters.
- Adds a start/busy/done handshake. Sits between display/counter logic and the board TX pin.

Parameters:
- CLK_DIV, 434, clock cycles per bit (434 gives 115200 baud at 50 MHz); legal range >= 2.
- DIGITS, 2, number of BCD digits per message; legal range 1..8.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- TERM_EN, 1, when 1 a terminator character is appended after the digits.
- TERM_CHAR, 8'h0D, terminator byte.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request to send one message; sampled only in IDLE.
- bcd  in  4*DIGITS  packed digits; bits [4*DIGITS-1 -: 4] hold the most-significant digit. Latched on accept.
- busy  out  1  high while a message is in flight.
- done  out  1  one-cycle pulse when the last stop bit completes.
- tx_out  out  1  serial line; idles high.

Behaviour:
- Reset (synchronous, rst high at a clk edge): tx_out=1, busy=0, done=0, state=IDLE, all counters cleared. Applies mid-frame too; tx_out returns high at that same edge. No partial frame resumes.
- Only `clk` edges act. All outputs are registered.
- States: IDLE -> START -> DATA -> (PARITY if PARITY!=0) -> STOP -> START (next char) or IDLE (last char).
- Accept: at an edge with state=IDLE and start=1:
  - bcd is latched, char index = 0, state = START.
  - busy=1 and tx_out=0 after that edge (zero-cycle latency to the start bit).
- Bit timing: each bit is held for exactly CLK_DIV cycles.
  - The baud counter counts 0..CLK_DIV-1 and advances the bit on terminal count.
  - Counter width is clog2(CLK_DIV).
- Frame: start bit (0), then 8 data bits LSB first, then optional parity bit, then STOP_BITS stop bits (1).
  - Bits per frame: F = 1 + 8 + (PARITY!=0) + STOP_BITS.
- Parity: even = XOR of the 8 data bits; odd = its inverse.
- Character mapping:
  - Digit 0..9 maps to 8'h30 + digit.
  - Digit 10..15 maps to 8'h3F ('?').
  - The terminator sends TERM_CHAR unchanged and is never mapped.
- Character count: C = DIGITS + TERM_EN. Characters are sent back-to-back with no idle gap; the next start bit directly follows the last stop bit.
- Completion: at edge A + C*F*CLK_DIV (A = accept edge):
  - state=IDLE, busy=0, tx_out=1, done=1.
  - done clears at the next edge.
- start while busy (including the done edge): ignored, no queueing. bcd changes while busy have no effect.
- start held high continuously: a new message is accepted on the first edge in IDLE, i.e. one cycle after done. Consecutive messages are therefore separated by exactly 1 idle-high cycle.
- Character index width is clog2(DIGITS+1). Bit index is 4 bits. No counter wraps except by explicit reload.

Test Plan:
1. Defaults with CLK_DIV=4, bcd=8'h12, start pulsed 1 cycle -> tx_out carries frames 0x31, 0x32, 0x0D, LSB first, each bit 4 cycles. busy high for exactly 120 cycles; done pulses once on the 120th edge after accept.
2. PARITY=1, DIGITS=1, TERM_EN=0, CLK_DIV=4, bcd=4'h1 -> frame 0,10001100,1,1 (parity 1 for 0x31). PARITY=2 gives parity bit 0. busy lasts 44 cycles.
3. Invalid digits: bcd=8'hA7 -> characters 0x3F, 0x37, 0x0D transmitted.
4. STOP_BITS=2, DIGITS=4, TERM_EN=0, bcd=16'h9021 -> 4 frames of 11 bits, no gaps. At CLK_DIV=4, busy lasts 176 cycles.
5. start re-pulsed mid-message with different bcd -> ignored; first message bits unchanged; no second done. With start held high, the second message's start bit begins exactly 1 cycle after done.
6. rst asserted during a DATA bit of frame 2 -> tx_out=1, busy=0, done=0 after that edge. A start after reset is released sends a complete, correct message from character 0.
